// File: rtl/matmul_stream_feeder.sv
// matmul_stream_feeder
//   AXI-Stream initiator for the 4x4 matmul accelerator. Operands A (words 0-15)
//   and B (words 16-31) are written through a simple register port. On start they
//   are streamed A-then-B, row-major, on the master stream. The 16-word result C
//   is then collected from the slave stream and can be read back through rd_addr/rd_data.
//
//   Optional feature macro: MATMUL_FEEDER_TIMEOUT_EN
//     When defined, a watchdog in RECV counts cycles with ss_tvalid=0. It is cleared
//     on every beat. When it reaches pTIMEOUT it sets timeout_err and ends the run.
//     When undefined, timeout_err is tied to 0 and RECV waits indefinitely.
//
// Ports
//   axis_clk, axis_rst_n   clock and synchronous reset (the reset is ACTIVE-HIGH despite its name)
//   wr_en/wr_addr/wr_data  operand buffer write; addr 0-15 -> A, addr 16-31 -> B
//   start                  run request; accepted in IDLE only
//   busy, done             busy in SEND/RECV; done is a one-cycle end-of-run pulse
//   tlast_err, timeout_err sticky status of the last run
//   rd_addr/rd_data        result readback (1-cycle latency)
//   sm_*                   operand stream out (to accelerator ss_*)
//   ss_*                   result stream in (from accelerator sm_*)
module matmul_stream_feeder #(
  parameter int pDATA_WIDTH = 32,
  parameter int pN_OPERAND  = 32,
  parameter int pN_RESULT   = 16,
  parameter int pTIMEOUT    = 1024
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   wr_en,
  input  logic [4:0]             wr_addr,
  input  logic [pDATA_WIDTH-1:0] wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   tlast_err,
  output logic                   timeout_err,
  input  logic [3:0]             rd_addr,
  output logic [pDATA_WIDTH-1:0] rd_data,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready
);

  localparam int TXW = $clog2(pN_OPERAND);
  localparam int RXW = $clog2(pN_RESULT);
  localparam logic [TXW-1:0] TX_LAST = TXW'(pN_OPERAND - 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(pN_RESULT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_DONE} state_t;

  state_t state, next_state;

  logic [pDATA_WIDTH-1:0] op_buf  [pN_OPERAND];
  logic [pDATA_WIDTH-1:0] res_buf [pN_RESULT];
  logic [TXW-1:0]         tx_cnt;
  logic [RXW-1:0]         rx_cnt;
  logic                   tx_beat;
  logic                   rx_beat;
  logic                   timeout_fire;

  // The stream outputs are decoded from the registered state. As a result, the
  // handshake beats only combine registered valid/ready with the partner's input.
  assign tx_beat = (state == S_SEND) && sm_tready;
  assign rx_beat = (state == S_RECV) && ss_tvalid;

  // ---- state register ----
  always_ff @(posedge axis_clk) begin
    if (axis_rst_n) state <= S_IDLE;
    else            state <= next_state;
  end

  // ---- next-state logic ----
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = S_SEND;
      S_SEND: if (tx_beat && (tx_cnt == TX_LAST)) next_state = S_RECV;
      S_RECV: if ((rx_beat && (rx_cnt == RX_LAST)) || timeout_fire) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // ---- output decode ----
  always_comb begin
    busy      = (state == S_SEND) || (state == S_RECV);
    done      = (state == S_DONE);
    sm_tvalid = (state == S_SEND);
    sm_tlast  = (state == S_SEND) && (tx_cnt == TX_LAST);
    sm_tdata  = (state == S_SEND) ? op_buf[tx_cnt] : '0;
    ss_tready = (state == S_RECV);
  end

  // ---- counters, buffers and status ----
  always_ff @(posedge axis_clk) begin
    if (axis_rst_n) begin
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      tlast_err <= 1'b0;
      rd_data   <= '0;
      for (int i = 0; i < pN_OPERAND; i++) op_buf[i]  <= '0;
      for (int i = 0; i < pN_RESULT;  i++) res_buf[i] <= '0;
    end else begin
      rd_data <= res_buf[rd_addr];
      case (state)
        S_IDLE: begin
          // If a write and start arrive in the same cycle, the write lands at this
          // edge, so SEND already sees the new word.
          if (wr_en) op_buf[wr_addr] <= wr_data;
          if (start) begin
            tx_cnt    <= '0;
            tlast_err <= 1'b0;
          end
        end
        S_SEND: begin
          if (tx_beat) begin
            tx_cnt <= tx_cnt + 1'b1;
            if (tx_cnt == TX_LAST) rx_cnt <= '0;
          end
        end
        S_RECV: begin
          if (rx_beat) begin
            res_buf[rx_cnt] <= ss_tdata;
            rx_cnt          <= rx_cnt + 1'b1;
            // A tlast on an early beat, or a missing tlast on the final beat, is
            // flagged. Reception still runs to the full word count.
            if (rx_cnt == RX_LAST) begin
              if (!ss_tlast) tlast_err <= 1'b1;
            end else if (ss_tlast) begin
              tlast_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MATMUL_FEEDER_TIMEOUT_EN
  localparam int IDW = $clog2(pTIMEOUT + 1);
  localparam logic [IDW-1:0] IDLE_LAST = IDW'(pTIMEOUT - 1);

  logic [IDW-1:0] idle_cnt;

  // The watchdog fires on the pTIMEOUT-th consecutive idle RECV cycle.
  assign timeout_fire = (state == S_RECV) && !ss_tvalid && (idle_cnt == IDLE_LAST);

  // ---- RX watchdog ----
  always_ff @(posedge axis_clk) begin
    if (axis_rst_n) begin
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state != S_RECV) || ss_tvalid) idle_cnt <= '0;
      else                                idle_cnt <= idle_cnt + 1'b1;
      if ((state == S_IDLE) && start) timeout_err <= 1'b0;
      else if (timeout_fire)          timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

endmodule
